key_conditioner: RTL and testbench

Input-conditioning stage between the board push-buttons and the game logic. It synchronises each raw key to `clk_i`, debounces it, and produces a clean level and a one-cycle press pulse per key. It also produces a per-frame key snapshot, latched on `new_frame_i`, that goes to the game logic's `keys_i`. Taps shorter than one frame are still seen by the game logic for the next frame.

---
 rtl/board_pkg.sv | 10 +
 rtl/key_debounce.sv | 121 ++++++++++++
 rtl/key_conditioner.sv | 66 ++++++
 tb/tb_key_conditioner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board-wide constants shared by the I/O conditioning blocks
package board_pkg;

  // Number of push-buttons on the board.
  localparam int KEYS_W = 4;

  // Stable cycles required before a key change is accepted (about 5 ms at 50 MHz).
  localparam int KEY_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - single-key synchroniser, debounce FSM and press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = board_pkg::KEY_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,    // raw key, already converted to 1 = pressed
  output logic level_o,  // accepted (debounced) level
  output logic press_o,  // registered one-cycle pulse after an accepted press
  output logic rise_o    // combinational: accepted press happens at the coming edge
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q;
  logic             rise;

  // Two-flop synchroniser; both stages idle at the released level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: the first differing cycle counts as 1, so a change is accepted
  // after DEBOUNCE_CYCLES consecutive differing synced samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          if (CNT_LAST == '0) begin
            state_d = PRESSED;
            rise    = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rise    = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          if (CNT_LAST == '0) begin
            state_d = RELEASED;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= rise;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rise_o  = rise;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key debounce plus per-frame sticky key snapshot
module key_conditioner
  import board_pkg::*;
#(
  parameter int NUM_KEYS        = KEYS_W,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic                new_frame_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] frame_keys_o
);

  logic [NUM_KEYS-1:0] keys_pressed;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] sticky_q, sticky_d;
  logic [NUM_KEYS-1:0] frame_q, frame_d;

  assign keys_pressed = KEYS_ACTIVE_LOW ? ~keys_i : keys_i;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .key_i  (keys_pressed[k]),
      .level_o(level[k]),
      .press_o(press[k]),
      .rise_o (rise[k])
    );
  end

  // Sticky collects accepted presses so a tap between strobes survives to the next
  // snapshot; a press landing on the strobe edge itself carries into the next frame.
  always_comb begin
    sticky_d = sticky_q | rise;
    frame_d  = frame_q;
    if (new_frame_i) begin
      frame_d  = level | sticky_q;
      sticky_d = rise;
    end
  end

  // Sticky and frame snapshot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
      frame_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      frame_q  <= frame_d;
    end
  end

  assign keys_o       = level;
  assign press_o      = press;
  assign frame_keys_o = frame_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed scoreboard bench for key_conditioner
module tb_key_conditioner;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [NK-1:0] keys_i;
  logic          new_frame_i;
  logic [NK-1:0] keys_o;
  logic [NK-1:0] press_o;
  logic [NK-1:0] frame_keys_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    string         tag;
    logic [NK-1:0] k;
    logic [NK-1:0] p;
    logic [NK-1:0] f;
  } exp_t;

  exp_t sb_q[$];

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .KEYS_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .keys_i      (keys_i),
    .new_frame_i (new_frame_i),
    .keys_o      (keys_o),
    .press_o     (press_o),
    .frame_keys_o(frame_keys_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // pr = keys physically pressed (1 = pressed); the board drives them active-low.
  task automatic step(input logic [NK-1:0] pr, input logic nf,
                      input logic [NK-1:0] ek, input logic [NK-1:0] ep,
                      input logic [NK-1:0] ef, input string tag);
    exp_t e;
    keys_i      = ~pr;
    new_frame_i = nf;
    sb_q.push_back('{tag: tag, k: ek, p: ep, f: ef});
    @(posedge clk);
    #1;
    new_frame_i = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, ".keys"},  keys_o,       e.k);
    chk({e.tag, ".press"}, press_o,      e.p);
    chk({e.tag, ".frame"}, frame_keys_o, e.f);
  endtask

  initial begin
    rst_ni      = 1'b0;
    keys_i      = '1;
    new_frame_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.keys",  keys_o,       '0);
    chk("reset.press", press_o,      '0);
    chk("reset.frame", frame_keys_o, '0);
    rst_ni = 1'b1;

    // key 0 press: accepted 5 edges after first sample, one press pulse
    for (int i = 0; i < 5; i++) step(4'h1, 1'b0, 4'h0, 4'h0, 4'h0, "p0_wait");
    step(4'h1, 1'b0, 4'h1, 4'h1, 4'h0, "p0_accept");
    step(4'h1, 1'b0, 4'h1, 4'h0, 4'h0, "p0_hold");
    step(4'h1, 1'b1, 4'h1, 4'h0, 4'h1, "p0_strobe");
    step(4'h1, 1'b0, 4'h1, 4'h0, 4'h1, "p0_frame_hold");
    // release: no pulse, level falls 5 edges later
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 4'h1, 4'h0, 4'h1, "r0_wait");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h1, "r0_accept");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, "r0_strobe");

    // glitch of 3 cycles is rejected
    for (int i = 0; i < 3; i++) step(4'h1, 1'b0, 4'h0, 4'h0, 4'h0, "glitch_low");
    for (int i = 0; i < 6; i++) step(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, "glitch_after");
    chk("glitch.cnt", NK'(dut.g_key[0].u_deb.cnt_q), '0);
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, "glitch_strobe");

    // short tap on key 1 between strobes
    for (int i = 0; i < 5; i++) step(4'h2, 1'b0, 4'h0, 4'h0, 4'h0, "tap_wait");
    step(4'h2, 1'b0, 4'h2, 4'h2, 4'h0, "tap_accept");
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 4'h2, 4'h0, 4'h0, "tap_rel_wait");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, "tap_released");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h2, "tap_strobe1");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h2, "tap_hold");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, "tap_strobe2");

    // key 2 accepted on the same edge as the strobe
    for (int i = 0; i < 5; i++) step(4'h4, 1'b0, 4'h0, 4'h0, 4'h0, "same_wait");
    step(4'h4, 1'b1, 4'h4, 4'h4, 4'h0, "same_strobe");
    step(4'h4, 1'b0, 4'h4, 4'h0, 4'h0, "same_hold");
    step(4'h4, 1'b1, 4'h4, 4'h0, 4'h4, "same_next_strobe");
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 4'h4, 4'h0, 4'h4, "same_rel_wait");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h4, "same_released");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, "same_final_strobe");

    // two keys pressed together, then released; then back-to-back strobes
    for (int i = 0; i < 5; i++) step(4'h3, 1'b0, 4'h0, 4'h0, 4'h0, "dual_wait");
    step(4'h3, 1'b0, 4'h3, 4'h3, 4'h0, "dual_accept");
    step(4'h3, 1'b0, 4'h3, 4'h0, 4'h0, "dual_hold");
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 4'h3, 4'h0, 4'h0, "dual_rel_wait");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, "dual_released");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h3, "consec_strobe1");
    step(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, "consec_strobe2");
    step(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, "consec_after");

    // reset while key 0 is in PRESS_WAIT and key 3 is accepted
    for (int i = 0; i < 5; i++) step(4'h8, 1'b0, 4'h0, 4'h0, 4'h0, "k3_wait");
    step(4'h8, 1'b0, 4'h8, 4'h8, 4'h0, "k3_accept");
    step(4'h8, 1'b1, 4'h8, 4'h0, 4'h8, "k3_strobe");
    for (int i = 0; i < 3; i++) step(4'h9, 1'b0, 4'h8, 4'h0, 4'h8, "k0_pwait");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst.keys",  keys_o,       '0);
    chk("async_rst.press", press_o,      '0);
    chk("async_rst.frame", frame_keys_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) step(4'h9, 1'b0, 4'h0, 4'h0, 4'h0, "post_rst_wait");
    step(4'h9, 1'b0, 4'h9, 4'h9, 4'h0, "post_rst_accept");
    step(4'h9, 1'b0, 4'h9, 4'h0, 4'h0, "post_rst_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
